fetch_queue_dual: RTL and testbench

- Dual-issue instruction fetch queue between the dual-port instruction memory / PC stage and the dual decode slots (ds1, ds2) of the superscalar datapath.
- Accepts up to two {instruction, PC} pairs per cycle and presents the two oldest entries to decode.
- Decode can consume 0, 1 or 2 entries per cycle, which decouples fetch from decode stalls. A flush port empties the queue on branch redirect.

---
 rtl/fetch_queue_dual_if.sv | 49 ++++
 rtl/fetch_queue_dual.sv | 110 +++++++++++
 tb/tb_fetch_queue_dual.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_dual_if.sv
// Fetch/decode bus of the dual-issue fetch queue.
// The master side is the fetch/decode environment; the slave side is the queue.
interface fetch_queue_dual_if #(
    parameter int IWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int AWIDTH   = 3
);
    // control
    logic                fq_i_ce;
    logic                fq_i_flush;

    // fetch side
    logic                fq_i_valid_1;
    logic                fq_i_valid_2;
    logic [IWIDTH-1:0]   fq_i_instr_1;
    logic [IWIDTH-1:0]   fq_i_instr_2;
    logic [PC_WIDTH-1:0] fq_i_pc_1;
    logic [PC_WIDTH-1:0] fq_i_pc_2;
    logic                fq_o_ready;

    // decode side
    logic                fq_i_deq_1;
    logic                fq_i_deq_2;
    logic                fq_o_valid_1;
    logic                fq_o_valid_2;
    logic [IWIDTH-1:0]   fq_o_instr_1;
    logic [IWIDTH-1:0]   fq_o_instr_2;
    logic [PC_WIDTH-1:0] fq_o_pc_1;
    logic [PC_WIDTH-1:0] fq_o_pc_2;
    logic [AWIDTH:0]     fq_o_count;

    modport master (
        output fq_i_ce, fq_i_flush,
        output fq_i_valid_1, fq_i_valid_2, fq_i_instr_1, fq_i_instr_2, fq_i_pc_1, fq_i_pc_2,
        input  fq_o_ready,
        output fq_i_deq_1, fq_i_deq_2,
        input  fq_o_valid_1, fq_o_valid_2, fq_o_instr_1, fq_o_instr_2,
        input  fq_o_pc_1, fq_o_pc_2, fq_o_count
    );

    modport slave (
        input  fq_i_ce, fq_i_flush,
        input  fq_i_valid_1, fq_i_valid_2, fq_i_instr_1, fq_i_instr_2, fq_i_pc_1, fq_i_pc_2,
        output fq_o_ready,
        input  fq_i_deq_1, fq_i_deq_2,
        output fq_o_valid_1, fq_o_valid_2, fq_o_instr_1, fq_o_instr_2,
        output fq_o_pc_1, fq_o_pc_2, fq_o_count
    );
endinterface

// File: rtl/fetch_queue_dual.sv
// Dual-issue instruction fetch queue: accepts up to two {instr, pc} pairs per
// cycle and presents the two oldest entries to the decode slots (first-word
// fall-through). Decode may consume 0, 1 or 2 entries; flush empties the queue.
module fetch_queue_dual #(
    parameter int IWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int DEPTH    = 8,
    parameter int AWIDTH   = 3
) (
    input  logic              fq_clk,
    input  logic              fq_rst,
    fetch_queue_dual_if.slave fq
);

    // ready means at least two free slots, so a full pair always fits
    localparam logic [AWIDTH:0] READY_MAX = (AWIDTH+1)'(DEPTH - 2);

    logic [AWIDTH-1:0]   head;
    logic [AWIDTH-1:0]   tail;
    logic [AWIDTH:0]     count;
    logic [AWIDTH:0]     count_next;
    logic [AWIDTH-1:0]   tail_plus_1;
    logic [AWIDTH-1:0]   head_plus_1;

    logic [IWIDTH-1:0]   instr_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

    logic                ready;
    logic                valid_1;
    logic                valid_2;
    logic                deq_1_eff;
    logic                deq_2_eff;
    logic [1:0]          enq;
    logic [1:0]          deq;

    assign ready       = (count <= READY_MAX);
    assign valid_1     = (count != '0);
    assign valid_2     = (count > (AWIDTH+1)'(1));
    assign tail_plus_1 = tail + AWIDTH'(1);
    assign head_plus_1 = head + AWIDTH'(1);

    // Enqueue/dequeue amounts; slot 2 only counts when slot 1 does
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        enq       = 2'd0;
        deq_1_eff = 1'b0;
        deq_2_eff = 1'b0;
        if (fq.fq_i_ce && ready && fq.fq_i_valid_1) begin
            enq = fq.fq_i_valid_2 ? 2'd2 : 2'd1;
        end
        if (fq.fq_i_ce && valid_1 && fq.fq_i_deq_1) begin
            deq_1_eff = 1'b1;
            deq_2_eff = valid_2 && fq.fq_i_deq_2;
        end
        deq        = {1'b0, deq_1_eff} + {1'b0, deq_2_eff};
        count_next = count + (AWIDTH+1)'(enq) - (AWIDTH+1)'(deq);
    end

    // Storage write: slot 1 at tail, slot 2 at tail+1 (may straddle the wrap)
    // NOTE: the entry arrays carry no reset; occupancy alone decides what is visible.
    always_ff @(posedge fq_clk) begin
        if (!fq.fq_i_flush && (enq != 2'd0)) begin
            instr_mem[tail] <= fq.fq_i_instr_1;
            pc_mem[tail]    <= fq.fq_i_pc_1;
            if (enq == 2'd2) begin
                instr_mem[tail_plus_1] <= fq.fq_i_instr_2;
                pc_mem[tail_plus_1]    <= fq.fq_i_pc_2;
            end
        end
    end

    // Pointer and occupancy update; flush wins over enqueue/dequeue and ce
    always_ff @(posedge fq_clk or negedge fq_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!fq_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fq.fq_i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AWIDTH'(deq);
            tail  <= tail + AWIDTH'(enq);
            count <= count_next;
        end
    end

    // Fall-through outputs, zeroed when the corresponding entry is absent
    always_comb begin
        fq.fq_o_ready   = ready;
        fq.fq_o_count   = count;
        fq.fq_o_valid_1 = valid_1;
        fq.fq_o_valid_2 = valid_2;
        fq.fq_o_instr_1 = '0;
        fq.fq_o_pc_1    = '0;
        fq.fq_o_instr_2 = '0;
        fq.fq_o_pc_2    = '0;
        if (valid_1) begin
            fq.fq_o_instr_1 = instr_mem[head];
            fq.fq_o_pc_1    = pc_mem[head];
        end
        if (valid_2) begin
            fq.fq_o_instr_2 = instr_mem[head_plus_1];
            fq.fq_o_pc_2    = pc_mem[head_plus_1];
        end
    end

endmodule

// File: tb/tb_fetch_queue_dual.sv
// Directed bench for fetch_queue_dual with a queue-based scoreboard of the
// expected FIFO contents.
module tb_fetch_queue_dual;

    localparam int IWIDTH   = 32;
    localparam int PC_WIDTH = 32;
    localparam int DEPTH    = 8;
    localparam int AWIDTH   = 3;

    typedef struct {
        logic [IWIDTH-1:0]   instr;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    logic   fq_clk = 1'b0;
    logic   fq_rst = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;
    entry_t sb[$];

    fetch_queue_dual_if #(.IWIDTH(IWIDTH), .PC_WIDTH(PC_WIDTH), .AWIDTH(AWIDTH)) fq_bus ();

    fetch_queue_dual #(
        .IWIDTH(IWIDTH), .PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)
    ) dut (
        .fq_clk (fq_clk),
        .fq_rst (fq_rst),
        .fq     (fq_bus.slave)
    );

    // Free-running clock
    always #5 fq_clk = ~fq_clk;

    function automatic logic [IWIDTH-1:0] instr_of(input logic [PC_WIDTH-1:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the scoreboard contents
    task automatic check_outputs(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"},   64'(fq_bus.fq_o_count),   64'(n));
        chk({tag, ".ready"},   64'(fq_bus.fq_o_ready),   64'(n <= DEPTH - 2));
        chk({tag, ".valid_1"}, 64'(fq_bus.fq_o_valid_1), 64'(n >= 1));
        chk({tag, ".valid_2"}, 64'(fq_bus.fq_o_valid_2), 64'(n >= 2));
        chk({tag, ".instr_1"}, 64'(fq_bus.fq_o_instr_1), (n >= 1) ? 64'(sb[0].instr) : 64'd0);
        chk({tag, ".pc_1"},    64'(fq_bus.fq_o_pc_1),    (n >= 1) ? 64'(sb[0].pc)    : 64'd0);
        chk({tag, ".instr_2"}, 64'(fq_bus.fq_o_instr_2), (n >= 2) ? 64'(sb[1].instr) : 64'd0);
        chk({tag, ".pc_2"},    64'(fq_bus.fq_o_pc_2),    (n >= 2) ? 64'(sb[1].pc)    : 64'd0);
    endtask

    task automatic drive_idle();
        fq_bus.fq_i_ce       = 1'b1;
        fq_bus.fq_i_flush    = 1'b0;
        fq_bus.fq_i_valid_1  = 1'b0;
        fq_bus.fq_i_valid_2  = 1'b0;
        fq_bus.fq_i_instr_1  = '0;
        fq_bus.fq_i_instr_2  = '0;
        fq_bus.fq_i_pc_1     = '0;
        fq_bus.fq_i_pc_2     = '0;
        fq_bus.fq_i_deq_1    = 1'b0;
        fq_bus.fq_i_deq_2    = 1'b0;
    endtask

    // One clock of stimulus: drive, update scoreboard, clock, then compare
    task automatic apply(input string tag, input logic ce, input logic flush,
                         input logic v1, input logic v2,
                         input logic [PC_WIDTH-1:0] p1, input logic [PC_WIDTH-1:0] p2,
                         input logic d1, input logic d2);
        int   n;
        logic acc, e1, e2;
        fq_bus.fq_i_ce      = ce;
        fq_bus.fq_i_flush   = flush;
        fq_bus.fq_i_valid_1 = v1;
        fq_bus.fq_i_valid_2 = v2;
        fq_bus.fq_i_instr_1 = instr_of(p1);
        fq_bus.fq_i_instr_2 = instr_of(p2);
        fq_bus.fq_i_pc_1    = p1;
        fq_bus.fq_i_pc_2    = p2;
        fq_bus.fq_i_deq_1   = d1;
        fq_bus.fq_i_deq_2   = d2;
        n = sb.size();
        if (flush) begin
            sb.delete();
        end else if (ce) begin
            acc = (n <= DEPTH - 2) && v1;
            e1  = d1 && (n >= 1);
            e2  = e1 && d2 && (n >= 2);
            if (e1) sb.delete(0);
            if (e2) sb.delete(0);
            if (acc) sb.push_back('{instr_of(p1), p1});
            if (acc && v2) sb.push_back('{instr_of(p2), p2});
        end
        @(posedge fq_clk);
        #1;
        drive_idle();
        check_outputs(tag);
    endtask

    initial begin
        logic [PC_WIDTH-1:0] pc;

        // Reset state
        drive_idle();
        fq_rst = 1'b0;
        repeat (2) @(posedge fq_clk);
        #1;
        check_outputs("reset");
        fq_rst = 1'b1;

        // First pair, with the literal instructions from the bring-up program
        fq_bus.fq_i_valid_1 = 1'b1;
        fq_bus.fq_i_valid_2 = 1'b1;
        fq_bus.fq_i_instr_1 = 32'h2008_0005;
        fq_bus.fq_i_pc_1    = 32'd0;
        fq_bus.fq_i_instr_2 = 32'h2009_0003;
        fq_bus.fq_i_pc_2    = 32'd4;
        sb.push_back('{32'h2008_0005, 32'd0});
        sb.push_back('{32'h2009_0003, 32'd4});
        @(posedge fq_clk);
        #1;
        drive_idle();
        check_outputs("first_pair");
        chk("first_pair.instr_1_lit", 64'(fq_bus.fq_o_instr_1), 64'h2008_0005);
        chk("first_pair.pc_2_lit",    64'(fq_bus.fq_o_pc_2),    64'd4);

        // Fill to DEPTH with no dequeue
        for (int k = 0; k < 3; k++) begin
            pc = PC_WIDTH'(8 + 8 * k);
            apply("fill", 1'b1, 1'b0, 1'b1, 1'b1, pc, pc + 4, 1'b0, 1'b0);
        end
        chk("full.count", 64'(fq_bus.fq_o_count), 64'd8);
        chk("full.ready", 64'(fq_bus.fq_o_ready),  64'd0);

        // A pair offered while full is dropped
        apply("drop_full", 1'b1, 1'b0, 1'b1, 1'b1, 32'd100, 32'd104, 1'b0, 1'b0);
        chk("drop_full.count", 64'(fq_bus.fq_o_count), 64'd8);

        // Full queue: dual dequeue plus an offered pair that must be refused
        apply("full_deq2", 1'b1, 1'b0, 1'b1, 1'b1, 32'd200, 32'd204, 1'b1, 1'b1);
        chk("full_deq2.count", 64'(fq_bus.fq_o_count), 64'd6);
        chk("full_deq2.pc_1",  64'(fq_bus.fq_o_pc_1),  64'd8);

        // Simultaneous enqueue and dual dequeue keeps count
        apply("enq_deq2", 1'b1, 1'b0, 1'b1, 1'b1, 32'd32, 32'd36, 1'b1, 1'b1);
        chk("enq_deq2.count", 64'(fq_bus.fq_o_count), 64'd6);
        chk("enq_deq2.pc_1",  64'(fq_bus.fq_o_pc_1),  64'd16);

        // Drain to three entries, then single-issue
        apply("drain2", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        apply("drain1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("three.count", 64'(fq_bus.fq_o_count), 64'd3);
        apply("single_deq", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("single_deq.pc_1",  64'(fq_bus.fq_o_pc_1),  64'd32);
        chk("single_deq.pc_2",  64'(fq_bus.fq_o_pc_2),  64'd36);
        chk("single_deq.count", 64'(fq_bus.fq_o_count), 64'd2);

        // deq_2 without deq_1 is ignored
        apply("deq2_only", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("deq2_only.count", 64'(fq_bus.fq_o_count), 64'd2);

        // Clock enable low: nothing moves
        apply("ce_low", 1'b0, 1'b0, 1'b1, 1'b1, 32'd300, 32'd304, 1'b1, 1'b1);
        chk("ce_low.pc_1", 64'(fq_bus.fq_o_pc_1), 64'd32);

        // valid_2 without valid_1 is ignored
        apply("v2_only", 1'b1, 1'b0, 1'b0, 1'b1, 32'd400, 32'd404, 1'b0, 1'b0);
        chk("v2_only.count", 64'(fq_bus.fq_o_count), 64'd2);

        // Empty the queue; pointers now sit at a non-zero index
        apply("empty", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

        // Wrap: ten enqueue/dequeue pairs, tail crosses 7 -> 0 repeatedly
        for (int k = 0; k < 10; k++) begin
            pc = PC_WIDTH'(8 * k);
            apply("wrap", 1'b1, 1'b0, 1'b1, 1'b1, pc, pc + 4, 1'b1, 1'b1);
        end
        chk("wrap.pc_1", 64'(fq_bus.fq_o_pc_1), 64'd72);
        chk("wrap.pc_2", 64'(fq_bus.fq_o_pc_2), 64'd76);

        // Build count=5, then flush with concurrent enqueue and deq_1
        apply("pre_flush_drain", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            pc = PC_WIDTH'(500 + 8 * k);
            apply("pre_flush_fill", 1'b1, 1'b0, 1'b1, 1'b1, pc, pc + 4, 1'b0, 1'b0);
        end
        apply("pre_flush_deq1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("pre_flush.count", 64'(fq_bus.fq_o_count), 64'd5);
        apply("flush", 1'b1, 1'b1, 1'b1, 1'b1, 32'd600, 32'd604, 1'b1, 1'b0);
        chk("flush.count",   64'(fq_bus.fq_o_count),   64'd0);
        chk("flush.valid_1", 64'(fq_bus.fq_o_valid_1), 64'd0);
        chk("flush.ready",   64'(fq_bus.fq_o_ready),   64'd1);

        // Refill a pair, then assert reset mid-cycle and check without an edge
        apply("refill", 1'b1, 1'b0, 1'b1, 1'b1, 32'd700, 32'd704, 1'b0, 1'b0);
        #2;
        fq_rst = 1'b0;
        #1;
        sb.delete();
        check_outputs("async_reset");
        chk("async_reset.ready", 64'(fq_bus.fq_o_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
